// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage mul/div issue bundle and HI/LO result side.
// master drives operands and issue, slave is the iterative engine.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [1:0]       forwardA_i;
  logic [1:0]       forwardB_i;
  logic [WIDTH-1:0] RS_data_i;
  logic [WIDTH-1:0] RT_data_i;
  logic [WIDTH-1:0] EX_MEM_data_i;
  logic [WIDTH-1:0] MEM_WB_data_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, forwardA_i, forwardB_i,
    output RS_data_i, RT_data_i,
    output EX_MEM_data_i, MEM_WB_data_i, flush_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, forwardA_i, forwardB_i,
    input  RS_data_i, RT_data_i,
    input  EX_MEM_data_i, MEM_WB_data_i, flush_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial MULT/MULTU/DIV/DIVU with HI/LO.
// Operands are sign-stripped at issue, signs reapplied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk_i,
  input logic      rst_i,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [1:0]       op_q;
  logic             sign_q, sign_r_q, done_q;
  logic [W2-1:0]    p_q;

  logic [WIDTH-1:0] opa, opb, a_abs, b_abs;
  logic             sgn, a_neg, b_neg;

  // forwarding select: 10 EX/MEM, 01 MEM/WB, else register file
  always_comb begin
    unique case (1'b1)
      bus.forwardA_i == 2'b10: opa = bus.EX_MEM_data_i;
      bus.forwardA_i == 2'b01: opa = bus.MEM_WB_data_i;
      default:                 opa = bus.RS_data_i;
    endcase
    unique case (1'b1)
      bus.forwardB_i == 2'b10: opb = bus.EX_MEM_data_i;
      bus.forwardB_i == 2'b01: opb = bus.MEM_WB_data_i;
      default:                 opb = bus.RT_data_i;
    endcase
  end

  assign sgn   = ~bus.op_i[0];
  assign a_neg = sgn & opa[WIDTH-1];
  assign b_neg = sgn & opb[WIDTH-1];
  assign a_abs = a_neg ? -opa : opa;
  assign b_abs = b_neg ? -opb : opb;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nxt;
  logic [W2:0]      div_sh;
  logic [WIDTH:0]   div_tr;
  logic [W2-1:0]    div_nxt;

  // one shift-add or one restoring-divide step
  always_comb begin
    mul_sum = {1'b0, p_q[W2-1:WIDTH]};
    if (p_q[0]) mul_sum = mul_sum + {1'b0, a_q};
    mul_nxt = {mul_sum, p_q[WIDTH-1:1]};
    div_sh  = {p_q, 1'b0};
    div_tr  = div_sh[W2:WIDTH] - {1'b0, b_q};
    div_nxt = div_tr[WIDTH] ? div_sh[W2-1:0]
            : {div_tr[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
  end

  logic [W2-1:0]    prod_f;
  logic [WIDTH-1:0] quo_f, rem_f, res_hi, res_lo;
  logic             s_op;

  // sign fix-up and divide-by-zero override
  always_comb begin
    s_op   = ~op_q[0];
    prod_f = (s_op & sign_q) ? -p_q : p_q;
    quo_f  = p_q[WIDTH-1:0];
    rem_f  = p_q[W2-1:WIDTH];
    if (s_op & sign_q)   quo_f = -quo_f;
    if (s_op & sign_r_q) rem_f = -rem_f;
    if (!op_q[1]) begin
      res_hi = prod_f[W2-1:WIDTH];
      res_lo = prod_f[WIDTH-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem_f;
      res_lo = quo_f;
    end
  end

  // control FSM, datapath registers and HI/LO commit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      p_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            a_q      <= a_abs;
            b_q      <= b_abs;
            op_q     <= bus.op_i;
            sign_q   <= a_neg ^ b_neg;
            sign_r_q <= a_neg;
            cnt_q    <= '0;
            p_q      <= bus.op_i[1] ? {{WIDTH{1'b0}}, a_abs}
                                    : {{WIDTH{1'b0}}, b_abs};
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else begin
            p_q   <= op_q[1] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_o = rst_i & (
    (state_q == IDLE & bus.start_i & ~bus.flush_i) |
    (state_q == RUN) | (state_q == FIX));
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Expected HI/LO pushed at issue, popped on done_o.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        done_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // result monitor
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      chk("done_pulse", {63'd0, done_prev}, 64'd0);
      chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hi", {32'd0, bus.hi_o}, {32'd0, e[63:32]});
        chk("lo", {32'd0, bus.lo_o}, {32'd0, e[31:0]});
        last_hi = e[63:32];
        last_lo = e[31:0];
      end
    end
    done_prev = bus.done_o & rst_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] op, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ex,
                       input logic [31:0] wb);
    @(posedge clk); #1;
    bus.op_i = op;
    bus.forwardA_i = fa;
    bus.forwardB_i = fb;
    bus.RS_data_i = rs;
    bus.RT_data_i = rt;
    bus.EX_MEM_data_i = ex;
    bus.MEM_WB_data_i = wb;
    bus.start_i = 1'b1;
  endtask

  task automatic wait_end(input int exp_len, input bit hold);
    int n = 0;
    @(negedge clk);
    while (bus.stall_o && n < 200) begin
      n++;
      @(posedge clk); #1;
      if (!hold) bus.start_i = 1'b0;
      @(negedge clk);
    end
    chk("stall_len", 64'(n), 64'(exp_len));
  endtask

  task automatic op_run(input logic [1:0] op, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ex,
                        input logic [31:0] wb, input logic [31:0] eh,
                        input logic [31:0] el);
    drive(op, fa, fb, rs, rt, ex, wb);
    sb.push_back({eh, el});
    wait_end(34, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    longint sp;
    bus.start_i = 1'b1;
    bus.op_i = 2'b00;
    bus.forwardA_i = 2'b00;
    bus.forwardB_i = 2'b00;
    bus.RS_data_i = 32'd3;
    bus.RT_data_i = 32'd4;
    bus.EX_MEM_data_i = '0;
    bus.MEM_WB_data_i = '0;
    bus.flush_i = 1'b0;
    #3;
    chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("rst_done", {63'd0, bus.done_o}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    bus.start_i = 1'b0;
    #20 rst_n = 1'b1;

    op_run(2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,
           32'hFFFFFFFE, 32'h00000001);
    op_run(2'b00, 2'b10, 2'b00, 32'd7, 32'd5, -32'sd3, 0,
           32'hFFFFFFFF, 32'hFFFFFFF1);
    op_run(2'b10, 2'b00, 2'b01, -32'sd7, 32'd9, 0, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    op_run(2'b11, 2'b00, 2'b00, 32'h1234, 32'd0, 0, 0,
           32'h00001234, 32'hFFFFFFFF);
    op_run(2'b10, 2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 0,
           32'h00000000, 32'h80000000);
    op_run(2'b11, 2'b11, 2'b11, 32'd100, 32'd7, 1, 1,
           32'd2, 32'd14);
    op_run(2'b10, 2'b00, 2'b10, 32'd100, 32'd1, -32'sd7, 0,
           32'd2, -32'sd14);

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom | 32'd1;
      p = 64'(a) * 64'(b);
      op_run(2'b01, 2'b00, 2'b00, a, b, 0, 0, p[63:32], p[31:0]);
      op_run(2'b11, 2'b00, 2'b00, a, b, 0, 0, a % b, a / b);
      sp = longint'($signed(a)) * longint'($signed(b));
      p = 64'(sp);
      op_run(2'b00, 2'b00, 2'b00, a, b, 0, 0, p[63:32], p[31:0]);
    end

    // flush during RUN cycle 10
    drive(2'b01, 2'b00, 2'b00, 32'd9, 32'd9, 0, 0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("flush_hi", {32'd0, bus.hi_o}, {32'd0, last_hi});
    chk("flush_lo", {32'd0, bus.lo_o}, {32'd0, last_lo});
    repeat (40) @(posedge clk);
    chk("flush_sb", 64'(sb.size()), 64'd0);

    // reset mid-RUN
    drive(2'b01, 2'b00, 2'b00, 32'd9, 32'd9, 0, 0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("arst_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("arst_lo", {32'd0, bus.lo_o}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("arst_hold_lo", {32'd0, bus.lo_o}, 64'd0);

    // start held high: one op, then re-issue after DONE
    drive(2'b01, 2'b00, 2'b00, 32'd3, 32'd4, 0, 0);
    sb.push_back({32'd0, 32'd12});
    wait_end(34, 1'b1);
    sb.push_back({32'd0, 32'd12});
    @(posedge clk); #1;
    @(negedge clk);
    chk("reissue", {63'd0, bus.stall_o}, 64'd1);
    @(posedge clk); #1 bus.start_i = 1'b0;
    wait_end(33, 1'b0);

    // flush with start in IDLE: no issue
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("fl_start_stall", {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fl_start_run", {63'd0, bus.stall_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_lo", {32'd0, bus.lo_o}, {32'd0, last_lo});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
